ppu_oam_dma_fsm: RTL and testbench

Writer side of sprite RAM (OAM). Executes CPU writes to OAMADDR ($2003) and OAMDATA ($2004), and runs the $4014 sprite DMA, which copies one 256-byte CPU page into sprite RAM. Drives `cpu_sprite_addr`, the OAMADDR value that the sprite load FSM uses as its scan start. Sits between the CPU register decode / CPU memory bus and the sprite RAM write port.

---
 rtl/ppu_oam_dma_fsm.sv | 122 ++++++++++++
 tb/tb_ppu_oam_dma_fsm.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/ppu_oam_dma_fsm.sv
// Sprite RAM writer: handles $2003/$2004 CPU writes and the $4014 sprite DMA
// that copies a 256-byte CPU page into OAM starting at the current OAMADDR.
module ppu_oam_dma_fsm (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  cpu_data_in,
  input  logic        oamaddr_wr,
  input  logic        oamdata_wr,
  input  logic        dma_wr,
  input  logic        cpu_cycle_odd,
  input  logic        render_busy,
  output logic        bus_req,
  input  logic        bus_grant,
  output logic [15:0] mem_addr,
  output logic        mem_rd,
  input  logic [7:0]  mem_data_in,
  output logic        cpu_stall,
  output logic [7:0]  spram_addr,
  output logic [7:0]  spram_data_out,
  output logic        spram_we,
  output logic [7:0]  cpu_sprite_addr,
  output logic        busy,
  output logic        dma_done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_ALIGN,
    S_ALIGN2,
    S_READ,
    S_WRITE
  } state_t;

  state_t      state_q;
  logic [7:0]  oam_addr_q;
  logic [7:0]  page_q;
  logic [7:0]  idx_q;
  logic        odd_lat_q;
  logic [7:0]  spram_addr_q;
  logic [7:0]  spram_data_q;
  logic        spram_we_q;

  // Bus request/stall/busy follow the state register directly, so an async
  // reset drops them immediately. Read and done are qualified by the grant so
  // a withdrawn grant freezes the transfer with no bus activity.
  always_comb begin
    busy      = (state_q != S_IDLE);
    bus_req   = busy;
    cpu_stall = busy;
    mem_rd    = (state_q == S_READ) && bus_grant;
    mem_addr  = (state_q == S_READ) ? {page_q, idx_q} : '0;
    dma_done  = (state_q == S_WRITE) && bus_grant && (idx_q == 8'hFF);
  end

  assign spram_addr      = spram_addr_q;
  assign spram_data_out  = spram_data_q;
  assign spram_we        = spram_we_q;
  assign cpu_sprite_addr = oam_addr_q;

  // Main FSM: register strobes in IDLE, DMA sequencing otherwise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      oam_addr_q   <= '0;
      page_q       <= '0;
      idx_q        <= '0;
      odd_lat_q    <= 1'b0;
      spram_addr_q <= '0;
      spram_data_q <= '0;
      spram_we_q   <= 1'b0;
    end else begin
      spram_we_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (dma_wr) begin
            page_q  <= cpu_data_in;
            idx_q   <= '0;
            state_q <= S_REQ;
          end else if (oamaddr_wr) begin
            oam_addr_q <= cpu_data_in;
          end else if (oamdata_wr) begin
            spram_addr_q <= oam_addr_q;
            spram_data_q <= cpu_data_in;
            spram_we_q   <= !render_busy;
            oam_addr_q   <= oam_addr_q + 8'd1;
          end
        end
        S_REQ: begin
          if (bus_grant) begin
            odd_lat_q <= cpu_cycle_odd;
            state_q   <= S_ALIGN;
          end
        end
        S_ALIGN: begin
          if (bus_grant) state_q <= odd_lat_q ? S_ALIGN2 : S_READ;
        end
        S_ALIGN2: begin
          if (bus_grant) state_q <= S_READ;
        end
        S_READ: begin
          if (bus_grant) state_q <= S_WRITE;
        end
        S_WRITE: begin
          if (bus_grant) begin
            spram_we_q   <= 1'b1;
            spram_addr_q <= oam_addr_q + idx_q;
            spram_data_q <= mem_data_in;
            if (idx_q == 8'hFF) begin
              state_q <= S_IDLE;
            end else begin
              idx_q   <= idx_q + 8'd1;
              state_q <= S_READ;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ppu_oam_dma_fsm.sv
// Scoreboard bench for ppu_oam_dma_fsm: stimulus pushes expected sprite RAM
// writes and DMA read addresses; a negedge monitor pops and compares them.
module tb_ppu_oam_dma_fsm;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  cpu_data_in;
  logic        oamaddr_wr, oamdata_wr, dma_wr;
  logic        cpu_cycle_odd, render_busy;
  logic        bus_req, bus_grant;
  logic [15:0] mem_addr;
  logic        mem_rd;
  logic [7:0]  mem_data_in;
  logic        cpu_stall;
  logic [7:0]  spram_addr, spram_data_out;
  logic        spram_we;
  logic [7:0]  cpu_sprite_addr;
  logic        busy, dma_done;

  ppu_oam_dma_fsm dut (
    .clk(clk), .rst(rst), .cpu_data_in(cpu_data_in),
    .oamaddr_wr(oamaddr_wr), .oamdata_wr(oamdata_wr), .dma_wr(dma_wr),
    .cpu_cycle_odd(cpu_cycle_odd), .render_busy(render_busy),
    .bus_req(bus_req), .bus_grant(bus_grant), .mem_addr(mem_addr),
    .mem_rd(mem_rd), .mem_data_in(mem_data_in), .cpu_stall(cpu_stall),
    .spram_addr(spram_addr), .spram_data_out(spram_data_out),
    .spram_we(spram_we), .cpu_sprite_addr(cpu_sprite_addr),
    .busy(busy), .dma_done(dma_done)
  );

  always #5 clk = ~clk;

  int unsigned checks = 0;
  int unsigned failures = 0;

  logic [15:0] exp_wr[$];   // {spram addr, data}
  logic [15:0] exp_rd[$];   // CPU memory read address
  logic [7:0]  m_oam;       // reference OAMADDR
  logic [7:0]  mem_key;

  function automatic logic [7:0] mem_fn(input logic [15:0] a);
    return a[7:0] ^ mem_key;
  endfunction

  // CPU memory: data appears the cycle after the read strobe and holds
  always @(posedge clk) if (mem_rd) mem_data_in <= mem_fn(mem_addr);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic chk_zero(input string name);
    chk(name, {bus_req, mem_rd, cpu_stall, spram_we, busy, dma_done}, 32'h0);
    chk({name, "_buses"}, {mem_addr, spram_addr, spram_data_out}, 32'h0);
    chk({name, "_oam"}, {24'h0, cpu_sprite_addr}, 32'h0);
  endtask

  // Monitor: every write/read the DUT presents must match the next expectation
  always @(negedge clk) begin
    if (!rst) begin
      if (spram_we) begin
        if (exp_wr.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_we actual=%0h required=none", {spram_addr, spram_data_out});
        end else begin
          chk("spram_write", {spram_addr, spram_data_out}, exp_wr.pop_front());
        end
      end
      if (mem_rd) begin
        if (!bus_grant) chk("rd_without_grant", 32'd1, 32'd0);
        if (exp_rd.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_rd actual=%0h required=none", mem_addr);
        end else begin
          chk("mem_addr", mem_addr, exp_rd.pop_front());
        end
      end
    end
  end

  task automatic reg_wr(input logic aw, input logic ow, input logic [7:0] d, input logic rb);
    @(posedge clk); #1;
    oamaddr_wr = aw; oamdata_wr = ow; cpu_data_in = d; render_busy = rb;
    if (aw) m_oam = d;
    else if (ow) begin
      if (!rb) exp_wr.push_back({m_oam, d});
      m_oam = m_oam + 8'd1;
    end
    @(posedge clk); #1;
    oamaddr_wr = 0; oamdata_wr = 0; render_busy = 0;
  endtask

  task automatic check_oam(input string name);
    @(negedge clk);
    chk(name, cpu_sprite_addr, m_oam);
  endtask

  task automatic run_dma(input logic [7:0] pg, input logic odd, input int gdelay,
                         input logic drops, input logic with_aw, input logic collide,
                         input int rst_at);
    int cyc;
    bit done, aborted, stall_bad;
    @(posedge clk); #1;
    dma_wr = 1; oamaddr_wr = with_aw; cpu_data_in = pg;
    cpu_cycle_odd = odd; bus_grant = 0;
    for (int i = 0; i < 256; i++) begin
      exp_rd.push_back({pg, 8'(i)});
      exp_wr.push_back({8'(m_oam + 8'(i)), mem_fn({pg, 8'(i)})});
    end
    @(posedge clk); #1;
    dma_wr = 0; oamaddr_wr = 0;
    stall_bad = 0;
    for (int k = 0; k < gdelay; k++) begin
      @(negedge clk);
      if (!cpu_stall || !bus_req) stall_bad = 1;
      @(posedge clk); #1;
    end
    bus_grant = 1;
    cyc = 0; done = 0; aborted = 0;
    while (!done && cyc < 3000) begin
      cyc++;
      if (drops && cyc > 1) bus_grant = ($urandom_range(3) != 0);
      dma_wr     = collide && (cyc == 100);
      oamdata_wr = collide && (cyc == 100);
      oamaddr_wr = collide && (cyc == 150);
      cpu_data_in = 8'($urandom);
      @(negedge clk);
      if (!cpu_stall || !busy) stall_bad = 1;
      if (rst_at >= 0 && mem_rd && mem_addr[7:0] == 8'(rst_at)) begin
        #2 rst = 1;
        #1 chk_zero("reset_mid_dma");
        exp_wr.delete(); exp_rd.delete();
        m_oam = 0;
        aborted = 1; done = 1;
      end else if (dma_done) begin
        done = 1;
      end else begin
        @(posedge clk); #1;
      end
    end
    dma_wr = 0; oamdata_wr = 0; oamaddr_wr = 0;
    chk("dma_stall_held", {31'd0, stall_bad}, 32'd0);
    if (!aborted) begin
      chk("dma_done_seen", {31'd0, done}, 32'd1);
      if (!drops) chk("dma_latency", cyc, odd ? 32'd515 : 32'd514);
      @(posedge clk); #1;
      bus_grant = 0;
      check_oam("oam_after_dma");
      chk("idle_after_dma", {busy, bus_req, cpu_stall}, 32'd0);
    end else begin
      bus_grant = 0;
      @(posedge clk); #1 rst = 0;
      repeat (5) @(posedge clk);
      #1 chk_zero("after_reset_release");
    end
  endtask

  initial begin
    rst = 1; cpu_data_in = 0; oamaddr_wr = 0; oamdata_wr = 0; dma_wr = 0;
    cpu_cycle_odd = 0; render_busy = 0; bus_grant = 0; mem_data_in = 0;
    m_oam = 0; mem_key = 0;
    repeat (3) @(posedge clk);
    #1 chk_zero("reset_state");
    rst = 0;

    // $2003 then $2004 across the wrap
    reg_wr(1, 0, 8'hFE, 0);
    reg_wr(0, 1, 8'hAA, 0);
    reg_wr(0, 1, 8'hBB, 0);
    reg_wr(0, 1, 8'hCC, 0);
    check_oam("oam_wrap");
    chk("oam_wrap_value", cpu_sprite_addr, 32'h01);

    // $2004 during render: no write, address still advances
    reg_wr(0, 1, 8'h55, 1);
    check_oam("oam_render_inc");

    // even-aligned DMA, immediate grant
    reg_wr(1, 0, 8'h10, 0);
    run_dma(8'h02, 0, 0, 0, 0, 0, -1);
    chk("oam_kept_10", cpu_sprite_addr, 32'h10);

    // odd alignment with grant delayed 5 cycles
    run_dma(8'h02, 1, 5, 0, 0, 0, -1);

    // dma_wr + oamaddr_wr together, then strobes mid-DMA
    mem_key = 8'h5A;
    run_dma(8'h37, 0, 2, 0, 1, 1, -1);
    chk("oam_after_collide", cpu_sprite_addr, 32'h10);

    // reset at idx 0x40, then a clean DMA
    run_dma(8'h80, 1, 0, 0, 0, 0, 32'h40);
    run_dma(8'h81, 0, 0, 0, 0, 0, -1);

    // randomized register traffic
    for (int n = 0; n < 40; n++)
      reg_wr($urandom_range(3) == 0, $urandom_range(1) == 1, 8'($urandom), $urandom_range(1) == 1);
    check_oam("oam_random");

    // randomized DMAs with grant dropouts
    for (int n = 0; n < 2; n++) begin
      mem_key = 8'($urandom);
      run_dma(8'($urandom), 1'($urandom), int'($urandom_range(4)), 1, 0, 0, -1);
    end

    repeat (3) @(posedge clk);
    chk("wr_queue_empty", exp_wr.size(), 32'd0);
    chk("rd_queue_empty", exp_rd.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
